// File: rtl/laser_feeder.sv
// ============================================================================
// Module      : laser_feeder
// Description : Streams a stored point set into a LASER circle solver, then
//               scores the two returned circle centres against the same points.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module laser_feeder #(
  parameter int          NUM_OBJ     = 40,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LD_EN,
  input  logic [5:0] LD_IDX,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  input  logic       START,
  output logic       BUSY,
  output logic       LASER_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] SCORE,
  output logic       RES_VALID,
  output logic       TIMEOUT
);

  localparam logic [5:0]  c_last_idx  = 6'(NUM_OBJ - 1);
  localparam logic [6:0]  c_num_obj   = 7'(NUM_OBJ);
  localparam logic [5:0]  c_score_max = 6'(NUM_OBJ);
  localparam logic [19:0] c_wait_last = TIMEOUT_CYC - 20'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FEED   = 3'd1,
    S_WAIT   = 3'd2,
    S_SCORE  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_idx;
  logic [19:0] r_wait_cnt;
  logic [3:0]  r_mem_x [NUM_OBJ];
  logic [3:0]  r_mem_y [NUM_OBJ];
  logic [3:0]  w_px;
  logic [3:0]  w_py;
  logic        w_hit;

  // Distances are at most 15 per axis, so the squared sum needs 9 bits.
  function automatic logic f_in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [8:0] d2;
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    d2 = ({5'd0, dx} * {5'd0, dx}) + ({5'd0, dy} * {5'd0, dy});
    return (d2 <= 9'd16);
  endfunction

  // Point memory is deliberately outside reset so points survive an abort.
  always_ff @(posedge CLK) begin
    if ((r_state == S_IDLE) && LD_EN && ({1'b0, LD_IDX} < c_num_obj)) begin
      r_mem_x[LD_IDX] <= LD_X;
      r_mem_y[LD_IDX] <= LD_Y;
    end
  end

  assign w_px  = r_mem_x[r_idx];
  assign w_py  = r_mem_y[r_idx];
  assign w_hit = f_in_circle(w_px, w_py, RES_C1X, RES_C1Y) ||
                 f_in_circle(w_px, w_py, RES_C2X, RES_C2Y);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (START) w_next = S_FEED;
      S_FEED:   if (r_idx == c_last_idx) w_next = S_WAIT;
      S_WAIT: begin
        if (DONE) begin
          w_next = S_SCORE;
        end else if (r_wait_cnt == c_wait_last) begin
          w_next = S_REPORT;
        end
      end
      S_SCORE:  if (r_idx == c_last_idx) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track r_state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BUSY       <= 1'b0;
      LASER_RST  <= 1'b1;
      RES_VALID  <= 1'b0;
      X          <= 4'd0;
      Y          <= 4'd0;
      RES_C1X    <= 4'd0;
      RES_C1Y    <= 4'd0;
      RES_C2X    <= 4'd0;
      RES_C2Y    <= 4'd0;
      SCORE      <= 6'd0;
      TIMEOUT    <= 1'b0;
      r_idx      <= 6'd0;
      r_wait_cnt <= 20'd0;
    end else begin
      BUSY      <= (w_next != S_IDLE);
      LASER_RST <= (w_next == S_IDLE);
      RES_VALID <= (w_next == S_REPORT);
      case (r_state)
        S_IDLE: begin
          if (START) begin
            X          <= r_mem_x[0];
            Y          <= r_mem_y[0];
            TIMEOUT    <= 1'b0;
            r_idx      <= 6'd0;
            r_wait_cnt <= 20'd0;
          end
        end
        S_FEED: begin
          if (r_idx == c_last_idx) begin
            r_wait_cnt <= 20'd0;
          end else begin
            r_idx <= r_idx + 6'd1;
            X     <= r_mem_x[r_idx + 6'd1];
            Y     <= r_mem_y[r_idx + 6'd1];
          end
        end
        S_WAIT: begin
          if (DONE) begin
            RES_C1X <= C1X;
            RES_C1Y <= C1Y;
            RES_C2X <= C2X;
            RES_C2Y <= C2Y;
            SCORE   <= 6'd0;
            r_idx   <= 6'd0;
          end else if (r_wait_cnt == c_wait_last) begin
            TIMEOUT <= 1'b1;
            SCORE   <= 6'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 20'd1;
          end
        end
        S_SCORE: begin
          if (w_hit && (SCORE != c_score_max)) begin
            SCORE <= SCORE + 6'd1;
          end
          if (r_idx != c_last_idx) begin
            r_idx <= r_idx + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
